intra_ang_filt4: RTL

- 4-pixel angular interpolation filter stage of the HEVC intra predictor.
- Consumes the 4 packed 5-bit fractional weights produced by the angular weight LUT stage, together with the 5 reference samples covering those 4 positions.
- Produces one row of 4 predicted samples per accepted beat: pred = ((32-w)*ref[i] + w*ref[i+1] + 16) >> 5.
- 2-stage pipeline with valid/ready handshake on both sides and a per-block row counter; feeds the prediction output buffer.

---
 rtl/intra_ang_filt4.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/intra_ang_filt4.sv
// intra_ang_filt4: 4-pixel HEVC intra angular interpolation filter stage.
// Each beat carries four 5-bit weights and five reference samples. The stage
// emits one row of four predictions through a 2-stage valid/ready pipeline:
//   pred_i = ((32 - w_i) * ref_i + w_i * ref_{i+1} + 16) >> 5
// S1 registers the weighted sums and S2 registers the rounded predictions.
// A per-block row counter tags each output row.
// Optional feature: define INTRA_ANG_FILT_SKID_EN to add a 1-entry skid
// register in front of S1. In that build in_ready is a flop, so there is no
// combinational path from out_ready to in_ready.
module intra_ang_filt4 #(
  parameter int unsigned BIT_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [19:0]            in_weight,
  input  logic [5*BIT_DEPTH-1:0] in_ref,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*BIT_DEPTH-1:0] out_pred,
  output logic                   out_last,
  output logic [5:0]             out_row_cnt,
  output logic                   busy
);

  // The largest sum is 32 * (2^BIT_DEPTH - 1), so it fits in BIT_DEPTH+5 bits.
  localparam int unsigned SumW = BIT_DEPTH + 5;
  localparam int unsigned RndW = SumW + 1;

  // Weighted sum for one pixel: (32 - w) * a + w * b.
  function automatic logic [SumW-1:0] interp(input logic [4:0]           w,
                                             input logic [BIT_DEPTH-1:0] a,
                                             input logic [BIT_DEPTH-1:0] b);
    logic [SumW-1:0] wa;
    logic [SumW-1:0] wb;
    wa = SumW'(6'd32 - {1'b0, w});
    wb = SumW'(w);
    return wa * SumW'(a) + wb * SumW'(b);
  endfunction

  // Pipeline state
  logic                   s1_valid_q, s1_valid_d;
  logic [SumW-1:0]        s1_sum_q [4];
  logic [SumW-1:0]        s1_sum_d [4];
  logic                   s1_last_q;
  logic                   s2_valid_q, s2_valid_d;
  logic [4*BIT_DEPTH-1:0] s2_pred_q, s2_pred_d;
  logic                   s2_last_q;
  logic [5:0]             row_cnt_q, row_cnt_d;

  // Handshake and source selection
  logic                   s2_adv;
  logic                   s1_free;
  logic                   s1_load;
  logic                   out_xfer;
  logic [19:0]            src_weight;
  logic [5*BIT_DEPTH-1:0] src_ref;
  logic                   src_last;

  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  // S1 can take a new beat if it is empty or its current beat moves to S2.
  assign s1_free  = ~s1_valid_q | s2_adv;
  assign out_xfer = s2_valid_q & out_ready;

`ifdef INTRA_ANG_FILT_SKID_EN

  logic                   skid_valid_q, skid_valid_d;
  logic [19:0]            skid_weight_q;
  logic [5*BIT_DEPTH-1:0] skid_ref_q;
  logic                   skid_last_q;
  logic                   skid_load;
  logic                   in_ready_q;
  logic                   in_xfer;

  assign in_ready = in_ready_q;
  assign in_xfer  = in_valid & in_ready_q;
  assign busy     = s1_valid_q | s2_valid_q | skid_valid_q;

  // Skid drains into S1 ahead of any new beat; a beat that cannot enter S1 is parked.
  always_comb begin
    src_weight   = in_weight;
    src_ref      = in_ref;
    src_last     = in_last;
    if (skid_valid_q) begin
      src_weight = skid_weight_q;
      src_ref    = skid_ref_q;
      src_last   = skid_last_q;
    end
    s1_load      = s1_free & (skid_valid_q | in_xfer);
    skid_load    = in_xfer & (~s1_free | skid_valid_q);
    skid_valid_d = skid_load | (skid_valid_q & ~s1_free);
  end

  // Skid register and registered ready, which is high only while the skid is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q  <= 1'b0;
      skid_weight_q <= '0;
      skid_ref_q    <= '0;
      skid_last_q   <= 1'b0;
      in_ready_q    <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      if (skid_load) begin
        skid_weight_q <= in_weight;
        skid_ref_q    <= in_ref;
        skid_last_q   <= in_last;
      end
    end
  end

`else

  assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;
  assign busy     = s1_valid_q | s2_valid_q;

  // Without a skid, the input feeds S1 directly.
  always_comb begin
    src_weight = in_weight;
    src_ref    = in_ref;
    src_last   = in_last;
    s1_load    = in_valid & in_ready;
  end

`endif

  // S1 next state: weighted sums of the selected source beat.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s1_sum_d[i] = interp(src_weight[19-5*i -: 5],
                           src_ref[i*BIT_DEPTH +: BIT_DEPTH],
                           src_ref[(i+1)*BIT_DEPTH +: BIT_DEPTH]);
    end
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        s1_sum_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_last_q <= src_last;
        for (int i = 0; i < 4; i++) begin
          s1_sum_q[i] <= s1_sum_d[i];
        end
      end
    end
  end

  // S2 next state: round and shift. The result never exceeds the larger ref, so no clip.
  always_comb begin
    logic [RndW-1:0] rnd;
    s2_pred_d = '0;
    for (int i = 0; i < 4; i++) begin
      rnd = {1'b0, s1_sum_q[i]} + RndW'(16);
      s2_pred_d[i*BIT_DEPTH +: BIT_DEPTH] = rnd[BIT_DEPTH+4:5];
    end
    s2_valid_d = s2_valid_q;
    if (s2_adv) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // S2 registers; held while stalled so the outputs stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_pred_q  <= '0;
      s2_last_q  <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_adv) begin
        s2_pred_q <= s2_pred_d;
        s2_last_q <= s1_last_q;
      end
    end
  end

  // Row counter: advances per output row and restarts after the block's last row.
  always_comb begin
    row_cnt_d = row_cnt_q;
    if (out_xfer) begin
      row_cnt_d = s2_last_q ? 6'd0 : row_cnt_q + 6'd1;
    end
  end

  // Row counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q <= 6'd0;
    end else begin
      row_cnt_q <= row_cnt_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_pred    = s2_pred_q;
  assign out_last    = s2_last_q;
  assign out_row_cnt = row_cnt_q;

endmodule
